// File: rtl/wb_arbiter_n.sv
// Shares one Wishbone slave among PORTS masters through a registered grant FSM (priority or round-robin).
// A per-transfer watchdog errors out a stalled slave so a hung peripheral cannot hold the bus forever.
module wb_arbiter_n #(
  parameter int    PORTS        = 4,
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 32,
  parameter int    SELECT_WIDTH = DATA_WIDTH / 8,
  parameter string ARB_TYPE     = "PRIORITY",
  parameter string LSB_PRIORITY = "HIGH",
  parameter int    TIMEOUT      = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORTS*ADDR_WIDTH-1:0]     wbm_adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]     wbm_dat_i,
  output logic [DATA_WIDTH-1:0]           wbm_dat_o,
  input  logic [PORTS-1:0]                wbm_we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0]   wbm_sel_i,
  input  logic [PORTS-1:0]                wbm_stb_i,
  input  logic [PORTS-1:0]                wbm_cyc_i,
  output logic [PORTS-1:0]                wbm_ack_o,
  output logic [PORTS-1:0]                wbm_err_o,
  output logic [PORTS-1:0]                wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]           wbs_adr_o,
  output logic [DATA_WIDTH-1:0]           wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
  output logic                            wbs_we_o,
  output logic [SELECT_WIDTH-1:0]         wbs_sel_o,
  output logic                            wbs_stb_o,
  output logic                            wbs_cyc_o,
  input  logic                            wbs_ack_i,
  input  logic                            wbs_err_i,
  input  logic                            wbs_rty_i,
  output logic [PORTS-1:0]                grant_o,
  output logic                            timeout_o
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit IS_RR    = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit LSB_HIGH = (LSB_PRIORITY == "HIGH");
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PORTS-1:0]  grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fire_q, fire_d;
  logic [IW-1:0]     win_idx;
  logic              g_cyc, g_stb, slv_resp;
  int                rank, best;

  // Lowest rank wins; rank 0 is the port directly after the last grant in round-robin mode.
  always_comb begin
    win_idx = '0;
    best    = PORTS;
    rank    = 0;
    for (int i = 0; i < PORTS; i++) begin
      if (IS_RR)         rank = (i + PORTS - 1 - int'(last_q)) % PORTS;
      else if (LSB_HIGH) rank = i;
      else               rank = PORTS - 1 - i;
      if (wbm_cyc_i[i] && rank < best) begin
        best    = rank;
        win_idx = IW'(i);
      end
    end
  end

  always_comb begin
    g_cyc     = |(wbm_cyc_i & grant_q);
    g_stb     = |(wbm_stb_i & grant_q);
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        wbs_adr_o = wbm_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wbs_dat_o = wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        wbs_sel_o = wbm_sel_i[i*SELECT_WIDTH +: SELECT_WIDTH];
        wbs_we_o  = wbm_we_i[i];
      end
    end
  end

  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|wbm_cyc_i) begin
          grant_d = PORTS'(1) << win_idx;
          last_d  = win_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!g_cyc) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (!g_stb || slv_resp) begin
          cnt_d = '0;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          // A response in this same cycle would have taken the branch above, so it wins.
          cnt_d   = '0;
          fire_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (!g_cyc) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(PORTS - 1);
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
    end
  end

  // Slave strobes follow the live cyc so a release takes effect in the same cycle.
  assign wbs_cyc_o = (state_q == S_GRANT) && g_cyc;
  assign wbs_stb_o = wbs_cyc_o && g_stb;
  assign wbm_ack_o = (state_q == S_GRANT) ? (grant_q & {PORTS{wbs_ack_i}}) : '0;
  assign wbm_rty_o = (state_q == S_GRANT) ? (grant_q & {PORTS{wbs_rty_i}}) : '0;
  assign wbm_err_o = (state_q == S_GRANT) ? (grant_q & {PORTS{wbs_err_i}}) : (grant_q & {PORTS{fire_q}});
  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = fire_q;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: three instances (priority/LSB high, priority/LSB low, round-robin) share master stimulus.
// A transaction-level model tracks owner/drain/stall per instance and every output is compared each cycle.
module tb_wb_arbiter_n;
  localparam int P = 4, DW = 32, AW = 32, SW = 4, TO = 8, ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P*AW-1:0] m_adr;
  logic [P*DW-1:0] m_dat;
  logic [P*SW-1:0] m_sel;
  logic [P-1:0]    m_we, m_stb, m_cyc;
  logic [DW-1:0]   s_dat [ND];
  logic [ND-1:0]   s_ack, s_err, s_rty;

  logic [DW-1:0]   o_mdat [ND];
  logic [P-1:0]    o_ack [ND], o_err [ND], o_rty [ND], o_grant [ND];
  logic [AW-1:0]   o_adr [ND];
  logic [DW-1:0]   o_sdat [ND];
  logic [SW-1:0]   o_sel [ND];
  logic            o_we [ND], o_stb [ND], o_cyc [ND], o_to [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wb_arbiter_n #(
      .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
      .ARB_TYPE(g == 2 ? "ROUND_ROBIN" : "PRIORITY"),
      .LSB_PRIORITY(g == 1 ? "LOW" : "HIGH"),
      .TIMEOUT(TO)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(o_mdat[g]),
      .wbm_we_i(m_we), .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
      .wbm_ack_o(o_ack[g]), .wbm_err_o(o_err[g]), .wbm_rty_o(o_rty[g]),
      .wbs_adr_o(o_adr[g]), .wbs_dat_o(o_sdat[g]), .wbs_dat_i(s_dat[g]),
      .wbs_we_o(o_we[g]), .wbs_sel_o(o_sel[g]), .wbs_stb_o(o_stb[g]), .wbs_cyc_o(o_cyc[g]),
      .wbs_ack_i(s_ack[g]), .wbs_err_i(s_err[g]), .wbs_rty_i(s_rty[g]),
      .grant_o(o_grant[g]), .timeout_o(o_to[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: who owns the bus, whether it is draining, stalled-strobe run length.
  int owner [ND], last [ND], stall [ND], quiet [ND];
  bit drain [ND], fire [ND];

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      owner[d] = -1; last[d] = P - 1; stall[d] = 0; drain[d] = 1'b0; fire[d] = 1'b0;
    end
  endtask

  function automatic int pick(input int d);
    int w = -1;
    for (int k = 0; k < P; k++) begin
      int p;
      if (d == 2)      p = (last[d] + 1 + k) % P;
      else if (d == 1) p = P - 1 - k;
      else             p = k;
      if (w < 0 && m_cyc[p]) w = p;
    end
    return w;
  endfunction

  function automatic bit exp_stb(input int d);
    int o = owner[d];
    return (o >= 0) && !drain[d] && m_cyc[o] && m_stb[o];
  endfunction

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      int o = owner[d];
      bit resp = s_ack[d] | s_err[d] | s_rty[d];
      fire[d] = 1'b0;
      if (!rst_n) begin
        owner[d] = -1; last[d] = P - 1; stall[d] = 0; drain[d] = 1'b0;
      end else if (o < 0) begin
        int w = pick(d);
        if (w >= 0) begin owner[d] = w; last[d] = w; stall[d] = 0; end
      end else if (!drain[d]) begin
        if (!m_cyc[o]) owner[d] = -1;
        else if (m_stb[o] && !resp) begin
          if (stall[d] == TO - 1) begin drain[d] = 1'b1; fire[d] = 1'b1; stall[d] = 0; end
          else stall[d]++;
        end else stall[d] = 0;
      end else if (!m_cyc[o]) begin
        owner[d] = -1; drain[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      int o;
      logic [P-1:0] g;
      bit live, inb;
      o = owner[d];
      g = '0;
      if (o >= 0) g[o] = 1'b1;
      inb  = (o >= 0) && !drain[d];
      live = inb && m_cyc[o];
      check($sformatf("u%0d_grant", d), o_grant[d], g);
      check($sformatf("u%0d_cyc", d), o_cyc[d], live);
      check($sformatf("u%0d_stb", d), o_stb[d], live && m_stb[o]);
      check($sformatf("u%0d_ack", d), o_ack[d], (inb && s_ack[d]) ? g : '0);
      check($sformatf("u%0d_err", d), o_err[d], ((inb && s_err[d]) || (drain[d] && fire[d])) ? g : '0);
      check($sformatf("u%0d_rty", d), o_rty[d], (inb && s_rty[d]) ? g : '0);
      check($sformatf("u%0d_tmo", d), o_to[d], fire[d]);
      check($sformatf("u%0d_rdat", d), o_mdat[d], s_dat[d]);
      if (live) begin
        check($sformatf("u%0d_adr", d), o_adr[d], m_adr[o*AW +: AW]);
        check($sformatf("u%0d_wdat", d), o_sdat[d], m_dat[o*DW +: DW]);
        check($sformatf("u%0d_sel", d), o_sel[d], m_sel[o*SW +: SW]);
        check($sformatf("u%0d_we", d), o_we[d], m_we[o]);
      end else if (o < 0) begin
        check($sformatf("u%0d_idle_bus", d), {o_adr[d], o_sdat[d]}, '0);
        check($sformatf("u%0d_idle_ctl", d), {o_sel[d], o_we[d]}, '0);
      end
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < P; k++) begin
      m_adr[k*AW +: AW] = $urandom;
      m_dat[k*DW +: DW] = $urandom;
      m_sel[k*SW +: SW] = SW'($urandom);
      m_we[k] = 1'($urandom_range(1));
    end
    for (int d = 0; d < ND; d++) s_dat[d] = $urandom;
  endtask

  // Called at a falling edge with inputs driven: check, advance model at the rising edge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rand_data();
  endtask

  task automatic slave_rand();
    for (int d = 0; d < ND; d++) begin
      int r;
      s_ack[d] = 1'b0; s_err[d] = 1'b0; s_rty[d] = 1'b0;
      if (quiet[d] > 0) quiet[d]--;
      else if ($urandom_range(24) == 0) quiet[d] = 12;
      else if (exp_stb(d) || (owner[d] >= 0 && drain[d])) begin
        r = $urandom_range(11);
        s_ack[d] = (r < 4); s_err[d] = (r == 4); s_rty[d] = (r == 5);
      end
    end
  endtask

  initial begin
    logic [P-1:0] order[$];
    logic [P-1:0] rr_exp [5];
    logic [P-1:0] prev, dropm;
    int gap, n;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    m_cyc = '0; m_stb = '0; s_ack = '0; s_err = '0; s_rty = '0;
    for (int d = 0; d < ND; d++) quiet[d] = 0;
    rand_data();
    model_reset();

    // Requests while in reset must not produce a grant.
    @(negedge clk);
    m_cyc = '1; m_stb = '1;
    #1 check("rst_grant", o_grant[0], 4'b0000);
    check("rst_cyc", o_cyc[2], 1'b0);
    cycle(); cycle();
    m_cyc = '0; m_stb = '0; rst_n = 1'b1;
    cycle();

    // Ports 1 and 3 request together.
    m_cyc = 4'b1010; m_stb = '0;
    cycle();
    check("d1_gnt_pri_high", o_grant[0], 4'b0010);
    check("d1_gnt_pri_low", o_grant[1], 4'b1000);
    check("d1_gnt_rr", o_grant[2], 4'b0010);
    cycle();
    m_cyc = 4'b1000;
    #1 check("d1_drop_gnt", o_grant[0], 4'b0010);
    check("d1_drop_cyc", o_cyc[0], 1'b0);
    cycle();
    check("d1_idle_gap", o_grant[0], 4'b0000);
    cycle();
    check("d1_next_gnt", o_grant[0], 4'b1000);
    m_cyc = '0;
    cycle(); cycle();

    // Round-robin: every port keeps requesting, each released after one acked transfer.
    prev = '0; dropm = '0; gap = 0;
    for (int k = 0; k < 60 && order.size() < 5; k++) begin
      m_cyc = ~dropm; m_stb = '1; s_err = '0; s_rty = '0;
      for (int d = 0; d < ND; d++) s_ack[d] = exp_stb(d);
      dropm = '0;
      if (s_ack[2] && owner[2] >= 0) dropm[owner[2]] = 1'b1;
      cycle();
      if (o_grant[2] != '0 && prev == '0) begin
        if (order.size() > 0) check("rr_gap", gap, 1);
        order.push_back(o_grant[2]);
        gap = 0;
      end else if (o_grant[2] == '0) gap++;
      prev = o_grant[2];
    end
    check("rr_grant_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) check($sformatf("rr_order%0d", i), order[i], rr_exp[i]);
    m_cyc = '0; m_stb = '0; s_ack = '0;
    cycle(); cycle();

    // Watchdog: port 2 strobes into a silent slave.
    m_cyc = 4'b0100; m_stb = 4'b0100;
    cycle();
    n = 0;
    while (o_stb[0] && n < 20) begin n++; cycle(); end
    check("to_stalled_cycles", n, TO);
    check("to_err", o_err[0], 4'b0100);
    check("to_pulse", o_to[0], 1'b1);
    check("to_cyc_off", o_cyc[0], 1'b0);
    m_cyc = 4'b0101;
    cycle();
    check("to_pulse_single", o_to[0], 1'b0);
    check("to_grant_held", o_grant[0], 4'b0100);
    cycle();
    m_cyc = 4'b0001; m_stb = '0;
    cycle();
    check("to_release", o_grant[0], 4'b0000);
    cycle();
    check("to_next_grant", o_grant[0], 4'b0001);
    m_cyc = '0;
    cycle(); cycle();

    // Slave answers on the last stalled cycle before the watchdog would fire.
    m_cyc = 4'b0100; m_stb = 4'b0100;
    cycle();
    for (int k = 0; k < TO - 1; k++) cycle();
    s_ack = '1;
    #1 check("late_ack", o_ack[0], 4'b0100);
    check("late_ack_no_err", o_err[0], 4'b0000);
    cycle();
    check("late_ack_no_tmo", o_to[0], 1'b0);
    check("late_ack_cyc", o_cyc[0], 1'b1);
    s_ack = '0; m_cyc = '0; m_stb = '0;
    cycle(); cycle();

    // Asynchronous reset in the middle of a granted, strobing transfer.
    m_cyc = 4'b0010; m_stb = 4'b0010;
    cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_mid_grant%0d", d), o_grant[d], 4'b0000);
      check($sformatf("rst_mid_cyc%0d", d), o_cyc[d], 1'b0);
      check($sformatf("rst_mid_stb%0d", d), o_stb[d], 1'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("rst_regrant", o_grant[0], 4'b0010);
    m_cyc = '0; m_stb = '0;
    cycle(); cycle();

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < P; p++) begin
        if (m_cyc[p]) begin
          if ($urandom_range(15) == 0) m_cyc[p] = 1'b0;
        end else if ($urandom_range(3) == 0) m_cyc[p] = 1'b1;
        m_stb[p] = ($urandom_range(7) != 0);
      end
      slave_rand();
      cycle();
    end
    m_cyc = '0; m_stb = '0; s_ack = '0; s_err = '0; s_rty = '0;
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
